// File: rtl/frac_ratio_gen_if.sv
// Control bus between the reference-domain register file and the
// fractional ratio generator: ratio request in, P/S prescaler loads out.
interface frac_ratio_gen_if #(
   parameter int P_WIDTH    = 5,
   parameter int S_WIDTH    = 3,
   parameter int INT_WIDTH  = 8,
   parameter int FRAC_WIDTH = 8
);
   logic                  en;
   logic [INT_WIDTH-1:0]  N_int;
   logic [FRAC_WIDTH-1:0] frac;
   logic [P_WIDTH-1:0]    Pi;
   logic [S_WIDTH-1:0]    Si;
   logic                  valid;
   logic                  ratio_err;

   modport master (
      output en, N_int, frac,
      input  Pi, Si, valid, ratio_err
   );

   modport slave (
      input  en, N_int, frac,
      output Pi, Si, valid, ratio_err
   );
endinterface

// File: rtl/frac_ratio_gen.sv
// MASH 1-1-1 sigma-delta ratio generator for a pulse-swallow fractional-N
// divider: each Fin cycle it picks N = N_int + y and splits it into P/S loads.

// One first-order accumulator; the carry out is its only overflow signal.
module frac_acc_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic [W-1:0] addend,
   output logic [W-1:0] part,
   output logic         carry
);
   logic [W-1:0] acc;
   logic [W:0]   sum;

   assign sum   = {1'b0, acc} + {1'b0, addend};
   assign part  = sum[W-1:0];
   assign carry = sum[W];

   always_ff @(posedge clk) begin
      if (rst || clr) acc <= '0;
      else            acc <= sum[W-1:0];
   end
endmodule

module frac_ratio_gen #(
   parameter int P_WIDTH    = 5,
   parameter int S_WIDTH    = 3,
   parameter int INT_WIDTH  = 8,
   parameter int FRAC_WIDTH = 8
) (
   input logic              Fin,
   input logic              rst,
   frac_ratio_gen_if.slave  bus
);
   localparam int STAGES = 3;
   localparam int NT_W   = INT_WIDTH + 2;
   localparam int PQ_W   = NT_W - S_WIDTH;

   typedef struct packed {
      logic [P_WIDTH-1:0] p;
      logic [S_WIDTH-1:0] s;
   } load_t;

   logic [STAGES-1:0][FRAC_WIDTH-1:0] addend;
   logic [STAGES-1:0][FRAC_WIDTH-1:0] part;
   logic [STAGES-1:0]                 carry;

   logic c2_d, c3_d, c3_dd;
   logic signed [3:0]      y, y_eff;
   logic signed [NT_W-1:0] nt;
   logic [PQ_W-1:0]        p_q;
   logic [S_WIDTH-1:0]     s_q;
   logic                   bad;
   load_t                  load_q;
   logic                   valid_q, err_q;

   // Each stage integrates the truncated sum of the stage before it.
   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_first
         assign addend[g] = bus.frac;
      end else begin : g_next
         assign addend[g] = part[g-1];
      end
      frac_acc_stage #(.W(FRAC_WIDTH)) u_acc (
         .clk    (Fin),
         .rst    (rst),
         .clr    (!bus.en),
         .addend (addend[g]),
         .part   (part[g]),
         .carry  (carry[g])
      );
   end

   always_ff @(posedge Fin) begin
      if (rst || !bus.en) begin
         c2_d  <= 1'b0;
         c3_d  <= 1'b0;
         c3_dd <= 1'b0;
      end else begin
         c2_d  <= carry[1];
         c3_d  <= carry[2];
         c3_dd <= c3_d;
      end
   end

   function automatic logic signed [3:0] b2s(input logic b);
      return {3'b000, b};
   endfunction

   // Noise-shaped sum c1 + (1-z^-1)c2 + (1-z^-1)^2 c3; stays inside [-3, +4].
   always_comb begin
      y     = b2s(carry[0]) + b2s(carry[1]) - b2s(c2_d)
            + b2s(carry[2]) - (b2s(c3_d) <<< 1) + b2s(c3_dd);
      y_eff = bus.en ? y : 4'sd0;
      nt    = $signed({2'b00, bus.N_int}) + {{(NT_W-4){y_eff[3]}}, y_eff};
      p_q   = nt[NT_W-1:S_WIDTH];
      s_q   = nt[S_WIDTH-1:0];
      bad   = nt[NT_W-1]
           || (p_q > PQ_W'((2 ** P_WIDTH) - 1))
           || (p_q < PQ_W'(s_q));
   end

   // An unrealisable ratio keeps the last good loads so the counters never
   // see a load they cannot execute.
   always_ff @(posedge Fin) begin
      if (rst) begin
         load_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (!bad) load_q <= '{p: p_q[P_WIDTH-1:0], s: s_q};
         valid_q <= 1'b1;
         err_q   <= bad;
      end
   end

   assign bus.Pi        = load_q.p;
   assign bus.Si        = load_q.s;
   assign bus.valid     = valid_q;
   assign bus.ratio_err = err_q;
endmodule

// File: tb/tb_frac_ratio_gen.sv
// Scoreboard bench for frac_ratio_gen: the driver pushes expected loads per
// Fin edge, the monitor pops and compares after each edge.
module tb_frac_ratio_gen;
   localparam int PW = 5, SW = 3, IW = 8, FW = 8;

   logic Fin = 1'b0;
   logic rst = 1'b1;

   frac_ratio_gen_if #(.P_WIDTH(PW), .S_WIDTH(SW), .INT_WIDTH(IW), .FRAC_WIDTH(FW)) ifc ();

   frac_ratio_gen #(.P_WIDTH(PW), .S_WIDTH(SW), .INT_WIDTH(IW), .FRAC_WIDTH(FW)) dut (
      .Fin (Fin),
      .rst (rst),
      .bus (ifc)
   );

   always #5 Fin = ~Fin;

   typedef struct {
      int pi;
      int si;
      int vld;
      int err;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;

   // reference model state
   int m_a1, m_a2, m_a3, m_c2d, m_c3d, m_c3dd;
   int m_pi, m_si, m_v, m_err, m_y;

   // DUT outputs captured after the most recent step
   int cap_pi, cap_si, cap_v, cap_err;

   int seq_a[20];
   int sum_half;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s actual=%0d expected=[%0d,%0d]", name, act, lo, hi);
      end
   endtask

   task automatic model_step(input int r, input int e, input int n, input int f);
      int s1, s2, s3, c1, c2, c3, nt, p, s;
      bit bad;
      m_y = 0;
      if (r != 0) begin
         m_a1 = 0; m_a2 = 0; m_a3 = 0; m_c2d = 0; m_c3d = 0; m_c3dd = 0;
         m_pi = 0; m_si = 0; m_v = 0; m_err = 0;
         return;
      end
      if (e == 0) begin
         m_a1 = 0; m_a2 = 0; m_a3 = 0; m_c2d = 0; m_c3d = 0; m_c3dd = 0;
      end else begin
         s1 = m_a1 + f;          c1 = s1 / 256;
         s2 = m_a2 + (s1 % 256); c2 = s2 / 256;
         s3 = m_a3 + (s2 % 256); c3 = s3 / 256;
         m_y = c1 + (c2 - m_c2d) + (c3 - 2 * m_c3d + m_c3dd);
         m_a1 = s1 % 256; m_a2 = s2 % 256; m_a3 = s3 % 256;
         m_c3dd = m_c3d; m_c3d = c3; m_c2d = c2;
      end
      nt = n + m_y;
      bad = 1'b1;
      if (nt >= 0) begin
         p = nt / 8;
         s = nt % 8;
         bad = (p > 31) || (p < s);
      end
      if (!bad) begin
         m_pi = p;
         m_si = s;
      end
      m_err = bad ? 1 : 0;
      m_v = 1;
   endtask

   task automatic step(input int r, input int e, input int n, input int f);
      exp_t x;
      @(negedge Fin);
      rst = (r != 0);
      ifc.en = (e != 0);
      ifc.N_int = IW'(n);
      ifc.frac = FW'(f);
      model_step(r, e, n, f);
      x.pi = m_pi; x.si = m_si; x.vld = m_v; x.err = m_err;
      q.push_back(x);
      @(posedge Fin);
      #2;
      cap_pi = int'(ifc.Pi);
      cap_si = int'(ifc.Si);
      cap_v = int'(ifc.valid);
      cap_err = int'(ifc.ratio_err);
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge Fin);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_pi", int'(ifc.Pi), e.pi);
            chk("sb_si", int'(ifc.Si), e.si);
            chk("sb_valid", int'(ifc.valid), e.vld);
            chk("sb_err", int'(ifc.ratio_err), e.err);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // driver
   initial begin
      ifc.en = 1'b1; ifc.N_int = 8'd67; ifc.frac = 8'h55;

      // reset hold
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 67, 8'h55);
         chk("rst_pi", cap_pi, 0);
         chk("rst_valid", cap_v, 0);
      end

      // integer mode
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 67, 8'h55);
         chk("int_pi", cap_pi, 8);
         chk("int_si", cap_si, 3);
         chk("int_valid", cap_v, 1);
         chk("int_err", cap_err, 0);
      end

      // integer-mode boundaries: largest realisable P, and P < S
      step(0, 0, 255, 0);
      chk("max_pi", cap_pi, 31);
      chk("max_si", cap_si, 7);
      step(0, 0, 9, 0);
      chk("p_eq1_pi", cap_pi, 1);
      chk("p_eq1_si", cap_si, 1);
      step(0, 0, 10, 0);
      chk("plts_err", cap_err, 1);
      chk("plts_hold_pi", cap_pi, 1);
      chk("plts_hold_si", cap_si, 1);

      // zero fraction
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 59, 0);
         chk("zero_pi", cap_pi, 7);
         chk("zero_si", cap_si, 3);
      end

      // half fraction
      sum_half = 0;
      for (int i = 0; i < 1024; i++) begin
         step(0, 1, 67, 128);
         chk_range("half_range", 8 * cap_pi + cap_si, 64, 71);
         sum_half += 8 * cap_pi + cap_si;
      end
      chk_range("half_sum", sum_half, 1024 * 67 + 512 - 3, 1024 * 67 + 512 + 3);

      // range error
      step(0, 0, 67, 0);
      step(0, 1, 67, 0);
      step(0, 1, 67, 0);
      chk("pre_err_pi", cap_pi, 8);
      step(0, 1, 7, 0);
      chk("rerr_flag", cap_err, 1);
      chk("rerr_hold_pi", cap_pi, 8);
      chk("rerr_hold_si", cap_si, 3);
      step(0, 1, 67, 0);
      chk("rerr_clear", cap_err, 0);

      // mid-operation reset: post-reset sequence must repeat exactly
      step(1, 1, 67, 8'h33);
      for (int i = 0; i < 20; i++) begin
         step(0, 1, 67, 8'h33);
         seq_a[i] = 8 * cap_pi + cap_si;
      end
      step(1, 1, 67, 8'h33);
      chk("mid_rst_pi", cap_pi, 0);
      chk("mid_rst_si", cap_si, 0);
      chk("mid_rst_valid", cap_v, 0);
      chk("mid_rst_err", cap_err, 0);
      for (int i = 0; i < 20; i++) begin
         step(0, 1, 67, 8'h33);
         chk("repeat_seq", 8 * cap_pi + cap_si, seq_a[i]);
      end

      @(negedge Fin);
      @(negedge Fin);
      chk("sb_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
